// File: rtl/clock_pkg.sv
// Shared types and timing constants for the multiplexed clock's time-of-day path.
package clock_pkg;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    SET_HRS = 2'd1,
    SET_MIN = 2'd2
  } mode_e;

  localparam int FREQUENCY       = 32768;
  localparam int HOLD_DEFAULT    = FREQUENCY / 2;
  localparam int REPEAT_DEFAULT  = FREQUENCY / 8;
  localparam int BLINK_DEFAULT   = FREQUENCY / 4;
  localparam int TIMEOUT_DEFAULT = 10;

endpackage

// File: rtl/clock_set_ctrl_btn_repeat.sv
// Rising-edge detector with press-and-hold auto-repeat; dropping en_i kills any
// pending repeat so a held button needs a fresh press to act again.
module btn_repeat
  import clock_pkg::*;
#(
  parameter int HOLD_CYCLES   = HOLD_DEFAULT,
  parameter int REPEAT_CYCLES = REPEAT_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en_i,
  input  logic btn_i,
  output logic rise_o,
  output logic fire_o
);

  localparam int MAX_CYCLES = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int CW = $clog2(MAX_CYCLES + 1);

  logic          prev_q;
  logic          active_q, active_d;
  logic          repeating_q, repeating_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] target;

  assign rise_o = btn_i & ~prev_q;
  assign target = repeating_q ? CW'(REPEAT_CYCLES) : CW'(HOLD_CYCLES);

  // cnt_q holds cycles since the last fire and reloads on reaching target
  always_comb begin
    active_d    = active_q;
    repeating_d = repeating_q;
    cnt_d       = cnt_q;
    fire_o      = 1'b0;
    if (!en_i || !btn_i) begin
      active_d    = 1'b0;
      repeating_d = 1'b0;
      cnt_d       = '0;
    end else if (rise_o) begin
      fire_o      = 1'b1;
      active_d    = 1'b1;
      repeating_d = 1'b0;
      cnt_d       = CW'(1);
    end else if (active_q) begin
      if (cnt_q == target) begin
        fire_o      = 1'b1;
        repeating_d = 1'b1;
        cnt_d       = CW'(1);
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_q      <= 1'b0;
      active_q    <= 1'b0;
      repeating_q <= 1'b0;
      cnt_q       <= '0;
    end else begin
      prev_q      <= btn_i;
      active_q    <= active_d;
      repeating_q <= repeating_d;
      cnt_q       <= cnt_d;
    end
  end

endmodule

// File: rtl/clock_set_ctrl.sv
// RUN / SET_HRS / SET_MIN mode controller: increment pulses with auto-repeat,
// seconds gating, inactivity timeout and blinking of the edited field.
module clock_set_ctrl
  import clock_pkg::*;
#(
  parameter int HOLD_CYCLES   = HOLD_DEFAULT,
  parameter int REPEAT_CYCLES = REPEAT_DEFAULT,
  parameter int BLINK_CYCLES  = BLINK_DEFAULT,
  parameter int TIMEOUT_SEC   = TIMEOUT_DEFAULT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_mode,
  input  logic       btn_inc,
  input  logic       sec_tick,
  output logic       run_en,
  output logic       clr_sec,
  output logic       inc_min,
  output logic       inc_hrs,
  output logic [3:0] digit_blank,
  output logic [1:0] mode
);

  localparam int TW = $clog2(TIMEOUT_SEC + 1);
  localparam int BW = $clog2(BLINK_CYCLES + 1);

  mode_e         state_q, state_d;
  logic          modePrev_q;
  logic [TW-1:0] tickCnt_q, tickCnt_d;
  logic [BW-1:0] blinkCnt_q, blinkCnt_d;
  logic          phase_q, phase_d;
  logic          runEn_q, runEn_d;
  logic          clrSec_q, clrSec_d;
  logic          incMin_q, incMin_d;
  logic          incHrs_q, incHrs_d;
  logic [3:0]    digitBlank_q, digitBlank_d;

  logic inSet, modeRise, incRise, incFire, anyEdge, timeoutHit, repEn;

  assign inSet      = (state_q != RUN);
  assign modeRise   = btn_mode & ~modePrev_q;
  assign anyEdge    = modeRise | incRise;
  assign timeoutHit = inSet & ~anyEdge & sec_tick & (tickCnt_q == TW'(TIMEOUT_SEC - 1));
  // A mode change or timeout exit suppresses increments and drops held-button repeat
  assign repEn      = inSet & ~modeRise & ~timeoutHit;

  btn_repeat #(
    .HOLD_CYCLES  (HOLD_CYCLES),
    .REPEAT_CYCLES(REPEAT_CYCLES)
  ) u_incRepeat (
    .clk   (clk),
    .rst_n (rst_n),
    .en_i  (repEn),
    .btn_i (btn_inc),
    .rise_o(incRise),
    .fire_o(incFire)
  );

  always_comb begin
    state_d  = state_q;
    clrSec_d = 1'b0;
    case (state_q)
      RUN:     if (modeRise) state_d = SET_HRS;
      SET_HRS: begin
        if (modeRise) state_d = SET_MIN;
        else if (timeoutHit) begin
          state_d  = RUN;
          clrSec_d = 1'b1;
        end
      end
      SET_MIN: begin
        if (modeRise || timeoutHit) begin
          state_d  = RUN;
          clrSec_d = 1'b1;
        end
      end
      default: state_d = RUN;
    endcase

    incHrs_d = incFire & (state_q == SET_HRS);
    incMin_d = incFire & (state_q == SET_MIN);
    runEn_d  = (state_d == RUN);

    tickCnt_d = tickCnt_q;
    if (state_d == RUN || anyEdge) tickCnt_d = '0;
    else if (sec_tick && tickCnt_q != TW'(TIMEOUT_SEC)) tickCnt_d = tickCnt_q + TW'(1);

    // Any press restarts the blink with the field visible
    blinkCnt_d = blinkCnt_q + BW'(1);
    phase_d    = phase_q;
    if (state_d == RUN || anyEdge) begin
      blinkCnt_d = '0;
      phase_d    = 1'b0;
    end else if (blinkCnt_q == BW'(BLINK_CYCLES - 1)) begin
      blinkCnt_d = '0;
      phase_d    = ~phase_q;
    end

    case (state_d)
      SET_HRS: digitBlank_d = {phase_d, phase_d, 2'b00};
      SET_MIN: digitBlank_d = {2'b00, phase_d, phase_d};
      default: digitBlank_d = 4'b0000;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= RUN;
      modePrev_q   <= 1'b0;
      tickCnt_q    <= '0;
      blinkCnt_q   <= '0;
      phase_q      <= 1'b0;
      runEn_q      <= 1'b1;
      clrSec_q     <= 1'b0;
      incMin_q     <= 1'b0;
      incHrs_q     <= 1'b0;
      digitBlank_q <= 4'b0000;
    end else begin
      state_q      <= state_d;
      modePrev_q   <= btn_mode;
      tickCnt_q    <= tickCnt_d;
      blinkCnt_q   <= blinkCnt_d;
      phase_q      <= phase_d;
      runEn_q      <= runEn_d;
      clrSec_q     <= clrSec_d;
      incMin_q     <= incMin_d;
      incHrs_q     <= incHrs_d;
      digitBlank_q <= digitBlank_d;
    end
  end

  assign mode        = state_q;
  assign run_en      = runEn_q;
  assign clr_sec     = clrSec_q;
  assign inc_min     = incMin_q;
  assign inc_hrs     = incHrs_q;
  assign digit_blank = digitBlank_q;

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Directed plus random stimulus for clock_set_ctrl, compared every cycle
// against an event-level model of the mode, repeat, timeout and blink rules.
module tb_clock_set_ctrl;

  localparam int HOLD    = 10;
  localparam int REPEAT  = 4;
  localparam int BLINK   = 8;
  localparam int TIMEOUT = 3;

  logic       clk, rst_n, btnMode, btnInc, secTick;
  logic       runEn, clrSec, incMin, incHrs;
  logic [3:0] digitBlank;
  logic [1:0] mode;

  int errors, checks, cycle;

  // Reference model state: ages measured in cycles or ticks since the last relevant event
  int         mMode, mAge, mTicks, mBlinkAge;
  bit         mPrevM, mPrevI, mArmed;
  int         eMode;
  bit         eRun, eClr, eMin, eHrs;
  logic [3:0] eBlank;

  clock_set_ctrl #(
    .HOLD_CYCLES  (HOLD),
    .REPEAT_CYCLES(REPEAT),
    .BLINK_CYCLES (BLINK),
    .TIMEOUT_SEC  (TIMEOUT)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .btn_mode   (btnMode),
    .btn_inc    (btnInc),
    .sec_tick   (secTick),
    .run_en     (runEn),
    .clr_sec    (clrSec),
    .inc_min    (incMin),
    .inc_hrs    (incHrs),
    .digit_blank(digitBlank),
    .mode       (mode)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic modelReset();
    mMode = 0; mAge = 0; mTicks = 0; mBlinkAge = 0;
    mPrevM = 0; mPrevI = 0; mArmed = 0;
    eMode = 0; eRun = 1; eClr = 0; eMin = 0; eHrs = 0; eBlank = 4'b0000;
  endtask

  task automatic modelStep(input bit m, input bit i, input bit t);
    bit me, ie, anyE, hit, fire, p;
    int nm;
    me = m && !mPrevM;
    ie = i && !mPrevI;
    anyE = me || ie;
    nm = mMode;
    eClr = 0; eHrs = 0; eMin = 0; fire = 0; hit = 0;
    if (mMode == 0) begin
      if (me) nm = 1;
      mArmed = 0;
    end else begin
      hit = !anyE && t && (mTicks + 1 == TIMEOUT);
      if (me) begin
        nm = (mMode == 1) ? 2 : 0;
        eClr = (mMode == 2);
        mArmed = 0;
      end else if (hit) begin
        nm = 0; eClr = 1; mArmed = 0;
      end else begin
        if (ie) begin
          fire = 1; mArmed = 1; mAge = 0;
        end else if (mArmed && i) begin
          mAge++;
          fire = (mAge == HOLD) || (mAge > HOLD && (mAge - HOLD) % REPEAT == 0);
        end
        if (!i) mArmed = 0;
        eHrs = fire && (mMode == 1);
        eMin = fire && (mMode == 2);
      end
    end
    if (nm == 0 || anyE) mTicks = 0;
    else if (t) mTicks++;
    if (nm == 0 || anyE) mBlinkAge = 0;
    else mBlinkAge++;
    p = ((mBlinkAge / BLINK) % 2) == 1;
    eBlank = (nm == 1) ? {p, p, 2'b00} : (nm == 2) ? {2'b00, p, p} : 4'b0000;
    eMode = nm;
    eRun = (nm == 0);
    mMode = nm;
    mPrevM = m;
    mPrevI = i;
  endtask

  task automatic checkOne(input string tag, input string name, input logic [3:0] got, input logic [3:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("[TB] FAIL %s %s: got %0h expected %0h", tag, name, got, exp);
    end
  endtask

  task automatic checkOutput(input string tag);
    checkOne(tag, "mode", {2'b00, mode}, 4'(eMode));
    checkOne(tag, "run_en", {3'b000, runEn}, {3'b000, eRun});
    checkOne(tag, "clr_sec", {3'b000, clrSec}, {3'b000, eClr});
    checkOne(tag, "inc_min", {3'b000, incMin}, {3'b000, eMin});
    checkOne(tag, "inc_hrs", {3'b000, incHrs}, {3'b000, eHrs});
    checkOne(tag, "digit_blank", digitBlank, eBlank);
  endtask

  task automatic applyStimulus(input bit m, input bit i, input bit t);
    btnMode = m;
    btnInc  = i;
    secTick = t;
    @(posedge clk);
    modelStep(m, i, t);
    cycle++;
    #1;
    checkOutput($sformatf("cyc%0d", cycle));
  endtask

  initial begin
    bit rm, ri, rt;
    errors = 0; checks = 0; cycle = 0;
    btnMode = 0; btnInc = 0; secTick = 0;
    rst_n = 1'b1;
    modelReset();
    #1 rst_n = 1'b0;
    #11 checkOutput("reset");
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Mode cycling RUN -> SET_HRS -> SET_MIN -> RUN
    applyStimulus(1, 0, 0);
    applyStimulus(0, 0, 0);
    applyStimulus(1, 0, 0);
    applyStimulus(1, 0, 0);
    applyStimulus(0, 0, 0);
    applyStimulus(1, 0, 0);
    applyStimulus(0, 0, 0);
    applyStimulus(0, 1, 0);
    applyStimulus(0, 0, 0);

    // Hold increment in SET_HRS for auto-repeat
    applyStimulus(1, 0, 0);
    applyStimulus(0, 0, 0);
    for (int k = 0; k < 40; k++) applyStimulus(0, 1, 0);
    for (int k = 0; k < 3; k++) applyStimulus(0, 0, 0);

    // SET_MIN timeout, restarted once by an increment press
    applyStimulus(1, 0, 0);
    applyStimulus(0, 0, 0);
    for (int k = 0; k < 8; k++) applyStimulus(0, 0, (k % 4) == 3);
    applyStimulus(0, 1, 0);
    applyStimulus(0, 0, 0);
    for (int k = 0; k < 16; k++) applyStimulus(0, 0, (k % 4) == 3);

    // Simultaneous mode and increment edges, then held increment across the change
    applyStimulus(1, 0, 0);
    applyStimulus(0, 0, 0);
    applyStimulus(1, 1, 0);
    for (int k = 0; k < 20; k++) applyStimulus(0, 1, 0);
    applyStimulus(0, 0, 0);
    applyStimulus(0, 1, 0);
    applyStimulus(0, 0, 0);

    // Blink in SET_MIN, press resets phase, edge coinciding with a tick
    for (int k = 0; k < 30; k++) applyStimulus(0, 0, 0);
    applyStimulus(0, 1, 0);
    for (int k = 0; k < 12; k++) applyStimulus(0, 0, 0);
    applyStimulus(0, 0, 1);
    applyStimulus(0, 0, 1);
    applyStimulus(0, 1, 1);
    applyStimulus(0, 0, 1);
    applyStimulus(1, 0, 0);
    for (int k = 0; k < 12; k++) applyStimulus(0, 0, 0);

    // Asynchronous reset in the middle of a repeat burst
    applyStimulus(1, 0, 0);
    applyStimulus(0, 0, 0);
    for (int k = 0; k < 15; k++) applyStimulus(0, 1, 0);
    #2 rst_n = 1'b0;
    #1 modelReset();
    checkOutput("asyncReset");
    @(posedge clk);
    #1 checkOutput("inReset");
    btnMode = 0;
    btnInc  = 0;
    rst_n   = 1'b1;
    for (int k = 0; k < 5; k++) applyStimulus(0, 0, 0);

    // Random button levels and tick strobes
    rm = 0; ri = 0;
    for (int k = 0; k < 700; k++) begin
      if ($urandom_range(0, 11) == 0) rm = ~rm;
      if ($urandom_range(0, 9) == 0) ri = ~ri;
      rt = ($urandom_range(0, 3) == 0);
      applyStimulus(rm, ri, rt);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/clock_set_ctrl.md
# clock_set_ctrl

Mode controller that sequences the time-of-day datapath of the multiplexed clock. It turns two debounced button levels into a RUN / SET_HRS / SET_MIN state machine. It issues single-cycle increment commands (with press-and-hold auto-repeat) to the hours and minutes counters, gates the seconds counter while setting, and produces a per-digit blank mask that blinks the field being edited. It sits between the debouncers and the timekeeping and display logic.

## Interface
Parameters:
- HOLD_CYCLES, 16384 — cycles btn_inc must stay high after the first increment before auto-repeat starts (0.5 s at 32768 Hz)
- REPEAT_CYCLES, 4096 — cycles between auto-repeat increments (0.125 s)
- BLINK_CYCLES, 8192 — half-period of the edit blink (0.25 s)
- TIMEOUT_SEC, 10 — sec_tick strobes without a button edge before a SET state falls back to RUN

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous, active-low
- btn_mode  in  1  debounced mode button, active-high level
- btn_inc  in  1  debounced increment button, active-high level
- sec_tick  in  1  one-cycle strobe, once per second, from the timekeeper
- run_en  out  1  high = seconds counter runs; low = hold
- clr_sec  out  1  one-cycle pulse: zero seconds and the quarter-minute LEDs
- inc_min  out  1  one-cycle pulse: minutes +1 (the timekeeper handles wrap)
- inc_hrs  out  1  one-cycle pulse: hours +1 (the timekeeper handles wrap)
- digit_blank  out  4  per-digit blank; bit0 min_u, bit1 min_d, bit2 hrs_u, bit3 hrs_d
- mode  out  2  0 RUN, 1 SET_HRS, 2 SET_MIN; 3 is never produced

## Operation
- Rising edges of btn_mode and btn_inc are detected against registered previous values. Both previous values reset to 0, so a button held through reset produces an edge on the first cycle after reset.
- **RUN:** a btn_mode edge moves to SET_HRS. btn_inc is ignored.
- **SET_HRS:** a btn_mode edge moves to SET_MIN. A btn_inc edge pulses inc_hrs.
- **SET_MIN:**
  - a btn_mode edge moves to RUN and pulses clr_sec.
  - a btn_inc edge pulses inc_min.
- **Auto-repeat:** while btn_inc stays high in a SET state, one extra pulse of the current field fires HOLD_CYCLES after the initial pulse, then every REPEAT_CYCLES. Releasing btn_inc clears the repeat counter.
- **Timeout:** in SET states, sec_tick strobes are counted. Any button edge clears the count. When the count reaches TIMEOUT_SEC, the state goes to RUN with a clr_sec pulse.
- **run_en:** 1 only in RUN.
- **Blink:** a phase bit toggles every BLINK_CYCLES in SET states.
  - SET_HRS: digit_blank = {phase, phase, 0, 0}.
  - SET_MIN: digit_blank = {0, 0, phase, phase}.
  - RUN: digit_blank = 0.
  - Any button edge forces phase to 0 and restarts the blink counter, so the edited digits are visible right after a press.
- **Simultaneous events:**
  - btn_mode edge and btn_inc edge in the same cycle: the mode change wins and no increment is issued.
  - Leaving a SET state with btn_inc held: auto-repeat stops. No increment occurs in the new state until btn_inc is released and pressed again.
  - Button edge and sec_tick in the same cycle: the timeout count clears (the edge wins).
- inc_min and inc_hrs are never high in the same cycle. inc_* and clr_sec are never high in the same cycle.
- All counters saturate or reload. None may wrap into a spurious pulse.

## Timing
- Reset values:
  - mode = RUN, run_en = 1, digit_blank = 0
  - clr_sec = 0, inc_min = 0, inc_hrs = 0
  - all counters 0, blink phase 0
- All outputs are registered. The cycle in which an input edge is sampled is N; the corresponding pulse, mode, run_en and digit_blank change are visible at N+1.
- Pulses are exactly one cycle wide.
- Auto-repeat: initial pulse at N+1, repeats at N+1+HOLD_CYCLES, then +REPEAT_CYCLES each.
- Timeout: the exit to RUN and the clr_sec pulse appear one cycle after the TIMEOUT_SEC-th sec_tick.
- rst_n asserted mid-SET: immediate return to reset values. No pulse is emitted on deassertion unless a button is high.
- Counter widths are $clog2(param+1).

## Structure
- Shared package clock_pkg holds:
  - mode enum: RUN = 0, SET_HRS = 1, SET_MIN = 2
  - FREQUENCY = 32768
  - default HOLD / REPEAT / BLINK cycle constants, derived from FREQUENCY
- One sub-module, btn_repeat: edge detection plus hold/repeat counter for btn_inc. It has an enable input, and clearing the enable kills the repeat state.

## Test plan
- Reset, then a btn_mode edge → mode=1 and run_en=0 at N+1. Second edge → mode=2. Third edge → mode=0 with clr_sec high for exactly 1 cycle.
- SET_HRS, btn_inc held for 40 cycles with HOLD=10, REPEAT=4 → inc_hrs at N+1, N+11, N+15, N+19, … and inc_min never asserted.
- SET_MIN with no buttons and TIMEOUT_SEC=3 → mode=0 and clr_sec one cycle after the 3rd sec_tick. A btn_inc edge before the 3rd tick restarts the count.
- btn_mode and btn_inc rise in the same cycle in SET_HRS → mode=2 and zero inc pulses. With btn_inc still held → no inc_min until release and re-press.
- SET_MIN with BLINK=8 → digit_blank toggles between 0000 and 0011 every 8 cycles. A btn_inc edge forces 0000 at N+1. In RUN, digit_blank stays 0000.
- rst_n asserted asynchronously mid-repeat in SET_HRS → outputs return to reset values without waiting for clk, and no inc pulse follows.
